// File: rtl/axi_ad9652_pack.sv
// Packs the two AD9652 16-bit channel streams into 64-bit words and queues them for the DMA.
// Optional AXI_AD9652_PACK_OVF_COUNT_EN adds a saturating ovf_count output.
module axi_ad9652_pack #(
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic        adc_clk,
  input  logic        adc_rstn,
  input  logic        adc_valid_0,
  input  logic        adc_enable_0,
  input  logic [15:0] adc_data_0,
  input  logic        adc_valid_1,
  input  logic        adc_enable_1,
  input  logic [15:0] adc_data_1,
  output logic        adc_dovf,
`ifdef AXI_AD9652_PACK_OVF_COUNT_EN
  output logic [15:0] ovf_count,
`endif
  output logic        dma_valid,
  output logic [63:0] dma_data,
  input  logic        dma_ready
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  logic [1:0]                 mask;
  logic [1:0]                 mask_q;
  logic                       mask_chg;
  logic                       both;
  logic                       beat;
  logic [1:0]                 pos;
  logic [1:0]                 pos_eff;
  logic [63:0]                partial;
  logic [63:0]                word_next;
  logic [15:0]                sel_data;
  logic                       last;
  logic                       push_req;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [FIFO_ADDR_WIDTH:0]   wr_ptr;
  logic [FIFO_ADDR_WIDTH:0]   rd_ptr;
  logic [63:0]                mem [DEPTH];

  assign mask     = {adc_enable_1, adc_enable_0};
  assign mask_chg = (mask != mask_q);
  assign both     = (mask == 2'b11);
  assign beat     = (mask != 2'b00) && (adc_valid_0 || !adc_enable_0) && (adc_valid_1 || !adc_enable_1);
  assign sel_data = adc_enable_1 ? adc_data_1 : adc_data_0;

  // A mask change restarts packing; the beat of that cycle lands in lane 0 of a fresh word.
  always_comb begin
    pos_eff   = mask_chg ? 2'd0 : pos;
    word_next = mask_chg ? 64'd0 : partial;
    if (both) begin
      if (pos_eff[0]) word_next[63:32] = {adc_data_1, adc_data_0};
      else            word_next[31:0]  = {adc_data_1, adc_data_0};
    end else begin
      case (pos_eff)
        2'd0:    word_next[15:0]  = sel_data;
        2'd1:    word_next[31:16] = sel_data;
        2'd2:    word_next[47:32] = sel_data;
        default: word_next[63:48] = sel_data;
      endcase
    end
    last = both ? pos_eff[0] : (pos_eff == 2'd3);
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                    (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign dma_valid = !empty;
  assign dma_data  = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign pop       = dma_valid && dma_ready;
  assign push_req  = beat && last;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the word.
  assign push      = push_req && (!full || pop);
  assign adc_dovf  = push_req && full && !pop;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      mask_q  <= 2'b00;
      pos     <= 2'd0;
      partial <= 64'd0;
    end else begin
      mask_q <= mask;
      if (beat) begin
        if (last) begin
          pos     <= 2'd0;
          partial <= 64'd0;
        end else begin
          pos     <= pos_eff + 2'd1;
          partial <= word_next;
        end
      end else if (mask_chg) begin
        pos     <= 2'd0;
        partial <= 64'd0;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else begin
      if (push) begin
        mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= word_next;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef AXI_AD9652_PACK_OVF_COUNT_EN
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      ovf_count <= 16'd0;
    end else if (mask_chg) begin
      ovf_count <= 16'd0;
    end else if (adc_dovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule
